idct_row_sched: RTL



---
 rtl/idct_row_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/idct_row_sched.sv
// Row-IDCT sequencer and 8x8 transpose buffer: loads 8 row results, then emits the block column by column.
// Optional statistics ports (blk_cnt, stall_cnt) are enabled by defining IDCT_ROW_SCHED_STATS_EN.
module idct_row_sched #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned RES_W = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*IN_W-1:0]    in_data,
  output logic [8*IN_W-1:0]    idct_in,
  input  logic [8*RES_W-1:0]   idct_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*RES_W-1:0]   out_data,
  output logic                 out_last
`ifdef IDCT_ROW_SCHED_STATS_EN
  ,
  output logic [15:0]          blk_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int unsigned N     = 8;
  localparam int unsigned ROW_W = N * RES_W;
  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   row_cnt, row_nxt;
  logic [CNT_W-1:0]   col_cnt, col_nxt;
  logic [CNT_W-1:0]   col_sel;
  logic [ROW_W-1:0]   row_buf [N];
  logic [ROW_W-1:0]   src_row;
  logic [ROW_W-1:0]   col_word;
  logic               buf_we;
  logic               in_hs, out_hs;
  logic               in_ready_nxt, out_valid_nxt, out_last_nxt;
  logic [ROW_W-1:0]   out_data_nxt;

  function automatic logic [RES_W-1:0] elem(input logic [ROW_W-1:0] row,
                                            input logic [CNT_W-1:0] c);
    return row[(N - 1 - 32'(c)) * RES_W +: RES_W];
  endfunction

  // The row IDCT datapath is combinational; its operand is the raw input word.
  assign idct_in = in_data;
  assign in_hs   = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;

  // Next column word to present; on the final row the incoming result stands in for buf[7].
  always_comb begin
    col_sel  = (state == DRAIN) ? col_cnt + CNT_W'(1) : '0;
    col_word = '0;
    src_row  = '0;
    for (int unsigned r = 0; r < N; r++) begin
      src_row = row_buf[r];
      if (state == LOAD && r == N - 1) src_row = idct_res;
      col_word[(N - 1 - r) * RES_W +: RES_W] = elem(src_row, col_sel);
    end
  end

  always_comb begin
    state_nxt     = state;
    row_nxt       = row_cnt;
    col_nxt       = col_cnt;
    buf_we        = 1'b0;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    out_data_nxt  = out_data;
    if (flush) begin
      state_nxt     = LOAD;
      row_nxt       = '0;
      col_nxt       = '0;
      in_ready_nxt  = 1'b1;
      out_valid_nxt = 1'b0;
      out_last_nxt  = 1'b0;
      out_data_nxt  = '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            buf_we  = 1'b1;
            row_nxt = row_cnt + CNT_W'(1);
            if (row_cnt == CNT_W'(N - 1)) begin
              state_nxt     = DRAIN;
              in_ready_nxt  = 1'b0;
              out_valid_nxt = 1'b1;
              out_last_nxt  = 1'b0;
              out_data_nxt  = col_word;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            col_nxt = col_cnt + CNT_W'(1);
            if (col_cnt == CNT_W'(N - 1)) begin
              state_nxt     = LOAD;
              in_ready_nxt  = 1'b1;
              out_valid_nxt = 1'b0;
              out_last_nxt  = 1'b0;
              out_data_nxt  = '0;
            end else begin
              out_data_nxt = col_word;
              out_last_nxt = (col_nxt == CNT_W'(N - 1));
            end
          end
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      row_cnt   <= '0;
      col_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_nxt;
      col_cnt   <= col_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      out_data  <= out_data_nxt;
    end
  end

  // Transpose storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (buf_we) row_buf[row_cnt] <= idct_res;
  end

`ifdef IDCT_ROW_SCHED_STATS_EN
  // Statistics survive flush; a flushed column-7 handshake is not a completed block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (!flush && out_hs && col_cnt == CNT_W'(N - 1)) blk_cnt <= blk_cnt + 16'd1;
      if (state == DRAIN && !out_ready) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
